// File: rtl/keypad_scan_pkg.sv
// Shared calculator definitions: key indices, operator codes (common with CU),
// debounce FSM encoding and the key-index to event decode.
package calc_pkg;

  localparam logic [3:0] KEY_1    = 4'd0;
  localparam logic [3:0] KEY_2    = 4'd1;
  localparam logic [3:0] KEY_3    = 4'd2;
  localparam logic [3:0] KEY_A    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_B    = 4'd7;
  localparam logic [3:0] KEY_7    = 4'd8;
  localparam logic [3:0] KEY_8    = 4'd9;
  localparam logic [3:0] KEY_9    = 4'd10;
  localparam logic [3:0] KEY_C    = 4'd11;
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_0    = 4'd13;
  localparam logic [3:0] KEY_HASH = 4'd14;
  localparam logic [3:0] KEY_D    = 4'd15;

  localparam logic [2:0] OPT_ADD = 3'd0;
  localparam logic [2:0] OPT_SUB = 3'd1;
  localparam logic [2:0] OPT_MUL = 3'd2;
  localparam logic [2:0] OPT_DIV = 3'd3;
  localparam logic [2:0] OPT_CLR = 3'd4;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_PRESS   = 2'd1,
    DB_HELD    = 2'd2,
    DB_RELEASE = 2'd3
  } db_state_t;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_NUM    = 2'd1,
    EV_OPT    = 2'd2,
    EV_SUBMIT = 2'd3
  } ev_kind_t;

  typedef struct packed {
    ev_kind_t   kind;
    logic [3:0] num;
    logic [2:0] opt;
  } key_event_t;

  function automatic key_event_t key_decode(input logic [3:0] k);
    key_event_t e;
    e.kind = EV_NUM;
    e.num  = 4'd0;
    e.opt  = 3'd0;
    case (k)
      KEY_1:    e.num = 4'd1;
      KEY_2:    e.num = 4'd2;
      KEY_3:    e.num = 4'd3;
      KEY_4:    e.num = 4'd4;
      KEY_5:    e.num = 4'd5;
      KEY_6:    e.num = 4'd6;
      KEY_7:    e.num = 4'd7;
      KEY_8:    e.num = 4'd8;
      KEY_9:    e.num = 4'd9;
      KEY_0:    e.num = 4'd0;
      KEY_A:    begin e.kind = EV_OPT; e.opt = OPT_ADD; end
      KEY_B:    begin e.kind = EV_OPT; e.opt = OPT_SUB; end
      KEY_C:    begin e.kind = EV_OPT; e.opt = OPT_MUL; end
      KEY_D:    begin e.kind = EV_OPT; e.opt = OPT_DIV; end
      KEY_STAR: begin e.kind = EV_OPT; e.opt = OPT_CLR; end
      KEY_HASH: e.kind = EV_SUBMIT;
      default:  e.kind = EV_NONE;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce.sv
// Frame-rate debounce FSM: qualifies a single stable key over DEBOUNCE frames
// and a clean release over DEBOUNCE empty frames; accept is a one-cycle strobe.
module key_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_done,
  input  logic [1:0] frame_n,
  input  logic [3:0] frame_k,
  output logic       accept,
  output logic [3:0] key,
  output logic [1:0] state_dbg
);

  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE);

  db_state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] key_q, key_d;
  logic [3:0] cnt_inc;

  assign cnt_inc   = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
  assign key       = key_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= DB_IDLE;
      cnt_q   <= 4'd0;
      key_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  // frame_n is 0, 1 or 2 (two or more keys); only an exact single key qualifies.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    accept  = 1'b0;
    if (frame_done) begin
      case (state_q)
        DB_IDLE: begin
          if (frame_n == 2'd1) begin
            key_d   = frame_k;
            cnt_d   = 4'd1;
            state_d = DB_PRESS;
          end
        end
        DB_PRESS: begin
          if (frame_n == 2'd1 && frame_k == key_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_LIMIT) begin
              accept  = 1'b1;
              state_d = DB_HELD;
            end
          end else begin
            cnt_d   = 4'd0;
            state_d = DB_IDLE;
          end
        end
        DB_HELD: begin
          if (frame_n == 2'd0) begin
            cnt_d   = 4'd1;
            state_d = DB_RELEASE;
          end
        end
        DB_RELEASE: begin
          if (frame_n == 2'd0) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_LIMIT) begin
              cnt_d   = 4'd0;
              state_d = DB_IDLE;
            end
          end else begin
            cnt_d   = 4'd0;
            state_d = DB_HELD;
          end
        end
        default: state_d = DB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: row drive, column synchroniser, per-frame
// summary, debounce and registered single-cycle CU events.
module keypad_scan
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] num,
  output logic       numPressed,
  output logic [2:0] opt,
  output logic       optPressed,
  output logic       submit
);

  localparam int             DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       col_s1, col_s2;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       row_q;
  logic [1:0]       acc_n;
  logic [3:0]       acc_k;
  logic             slot_end, frame_done;
  logic [1:0]       slot_n, slot_c;
  logic [1:0]       sum_n;
  logic [3:0]       sum_k;
  logic             accept, fire;
  logic [3:0]       db_key;
  logic [1:0]       db_state;
  key_event_t       ev;

  assign row        = ~(4'b0001 << row_q);
  assign slot_end   = (div_q == DIV_LAST);
  assign frame_done = slot_end && (row_q == 2'd3);

  // Pressed-column count (saturating at 2) and highest pressed column this slot.
  always_comb begin
    slot_n = 2'd0;
    slot_c = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!col_s2[c]) begin
        slot_c = 2'(c);
        slot_n = (slot_n == 2'd0) ? 2'd1 : 2'd2;
      end
    end
  end

  always_comb begin
    if (acc_n == 2'd0)       sum_n = slot_n;
    else if (slot_n == 2'd0) sum_n = acc_n;
    else                     sum_n = 2'd2;
    sum_k = (slot_n != 2'd0) ? {row_q, slot_c} : acc_k;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
      div_q  <= '0;
      row_q  <= 2'd0;
      acc_n  <= 2'd0;
      acc_k  <= 4'd0;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
      if (slot_end) begin
        div_q <= '0;
        row_q <= row_q + 2'd1;
        if (frame_done) begin
          acc_n <= 2'd0;
          acc_k <= 4'd0;
        end else begin
          acc_n <= sum_n;
          acc_k <= sum_k;
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .frame_done (frame_done),
    .frame_n    (sum_n),
    .frame_k    (sum_k),
    .accept     (accept),
    .key        (db_key),
    .state_dbg  (db_state)
  );

  // A press is only ever accepted on the PRESS -> HELD step.
  assign fire = accept && (db_state == DB_PRESS);
  assign ev   = key_decode(db_key);

  always_ff @(posedge clk) begin
    if (!reset) begin
      num        <= 4'd0;
      numPressed <= 1'b0;
      opt        <= 3'd0;
      optPressed <= 1'b0;
      submit     <= 1'b0;
    end else begin
      numPressed <= fire && (ev.kind == EV_NUM);
      num        <= (fire && ev.kind == EV_NUM) ? ev.num : 4'd0;
      optPressed <= fire && (ev.kind == EV_OPT);
      opt        <= (fire && ev.kind == EV_OPT) ? ev.opt : 3'd0;
      submit     <= fire && (ev.kind == EV_SUBMIT);
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model, directed key scenarios,
// expected-event queue checked by an independent output monitor.
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = 16;
  localparam int W        = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row, col, num;
  logic [2:0] opt;
  logic       numPressed, optPressed, submit;
  logic [15:0] keys = '0;

  int cyc = 0;
  int t0 = 0;
  int ev_count = 0;
  int last_ev_cyc = 0;
  int checks = 0;
  int errors = 0;
  int base = 0;
  int tst = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act;
  logic [3:0]   er;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk        (clk),
    .reset      (reset),
    .row        (row),
    .col        (col),
    .num        (num),
    .numPressed (numPressed),
    .opt        (opt),
    .optPressed (optPressed),
    .submit     (submit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad: a held key at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [W-1:0] ev_num(input int n);
    return {2'd1, 4'(n), 3'd0};
  endfunction
  function automatic logic [W-1:0] ev_opt(input int o);
    return {2'd2, 4'd0, 3'(o)};
  endfunction
  function automatic logic [W-1:0] ev_sub();
    return {2'd3, 7'd0};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_ev(input int target, input int budget, input string name);
    int n = 0;
    while (ev_count < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (ev_count < target) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, events %0d need %0d", name, n, ev_count, target);
    end
  endtask

  // Monitor: every output event is popped against the expected queue.
  always @(negedge clk) begin
    if (reset) begin
      if (numPressed || optPressed || submit) begin
        check("one_hot", int'(numPressed) + int'(optPressed) + int'(submit), 1);
        if (numPressed)      act = {2'd1, num, opt};
        else if (optPressed) act = {2'd2, num, opt};
        else                 act = {2'd3, num, opt};
        ev_count++;
        last_ev_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %0h expected none", act);
        end else begin
          check("event", act, exp_q.pop_front());
        end
      end else begin
        check("idle_outputs", {25'd0, num, opt}, 0);
      end
    end
  end

  initial begin
    // Reset state and bare scan
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_row", row, 4'b1110);
    check("reset_outs", {num, numPressed, opt, optPressed, submit}, 0);
    release_reset();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      @(negedge clk);
      er = ~(4'b0001 << (((i + 1) / 4) % 4));
      check("row_scan", row, er);
    end
    idle(4 * FRAME);
    check("no_key_no_event", ev_count, 0);

    // Key 2 held 10 frames from reset release
    assert_reset();
    keys = '0;
    keys[1] = 1'b1;
    base = ev_count;
    exp_q.push_back(ev_num(2));
    release_reset();
    wait_ev(base + 1, 80, "key2_event");
    check("key2_latency", last_ev_cyc - t0, 48);
    while (cyc - t0 < 10 * FRAME) @(posedge clk);
    #1;
    keys = '0;
    idle(6 * FRAME);
    check("key2_no_repeat", ev_count - base, 1);

    // Sequence 3, A, 1, #
    assert_reset();
    keys = '0;
    release_reset();
    base = ev_count;
    begin
      int seq_k[4];
      logic [W-1:0] seq_e[4];
      seq_k = '{2, 3, 0, 14};
      seq_e[0] = ev_num(3);
      seq_e[1] = ev_opt(0);
      seq_e[2] = ev_num(1);
      seq_e[3] = ev_sub();
      for (int i = 0; i < 4; i++) begin
        keys = '0;
        keys[seq_k[i]] = 1'b1;
        exp_q.push_back(seq_e[i]);
        idle(5 * FRAME);
        keys = '0;
        idle(5 * FRAME);
      end
    end
    check("seq_count", ev_count - base, 4);

    // Key 5 bouncing, then stable
    base = ev_count;
    exp_q.push_back(ev_num(5));
    for (int i = 0; i < 6; i++) begin
      keys[5] = ~keys[5];
      idle(5);
    end
    check("key5_quiet_while_bouncing", ev_count - base, 0);
    keys[5] = 1'b1;
    tst = cyc;
    wait_ev(base + 1, 8 * FRAME, "key5_event");
    idle(2 * FRAME);
    keys = '0;
    idle(6 * FRAME);
    check("key5_single", ev_count - base, 1);

    // Keys 1 and 4 together: ghosting guard, then release 4
    base = ev_count;
    keys = '0;
    keys[0] = 1'b1;
    keys[4] = 1'b1;
    idle(6 * FRAME);
    check("ghost_none", ev_count - base, 0);
    exp_q.push_back(ev_num(1));
    keys[4] = 1'b0;
    wait_ev(base + 1, 5 * FRAME, "key1_event");
    idle(2 * FRAME);
    keys = '0;
    idle(6 * FRAME);
    check("key1_single", ev_count - base, 1);

    // Reset pulse during PRESS of key 7
    assert_reset();
    keys = '0;
    keys[8] = 1'b1;
    release_reset();
    base = ev_count;
    exp_q.push_back(ev_num(7));
    idle(40);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_outs", {num, numPressed, opt, optPressed, submit}, 0);
    check("midreset_row", row, 4'b1110);
    check("midreset_no_event", ev_count - base, 0);
    reset = 1'b1;
    t0 = cyc;
    wait_ev(base + 1, 80, "key7_event");
    check("key7_latency", last_ev_cyc - t0, 48);
    keys = '0;
    idle(6 * FRAME);
    check("key7_single", ev_count - base, 1);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
